// File: rtl/booth_enc_stage.sv
// booth_enc_stage: registered radix-4 Booth encoder stage.
// Encodes a signed multiplier into NUM_PP 3-bit Booth codes ({negate, mag[1:0]},
// mag 00=zero, 01=x1, 10=x2). Each code is stored next to its multiplicand in a
// 2-entry buffer, so in_ready is registered and no input reaches an output
// combinationally.
// Optional build macro BOOTH_ZERO_FLAG_EN adds out_zero, a per-entry flag that
// marks an all-zero product.
module booth_enc_stage #(
  parameter  int DATA_W = 16,
  localparam int NUM_PP = DATA_W / 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     multiplicand,
  input  logic [DATA_W-1:0]     multiplier,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [3*NUM_PP-1:0]   out_enc
`ifdef BOOTH_ZERO_FLAG_EN
  ,
  output logic                  out_zero
`endif
);

  // Multiplier with the implicit zero appended below bit 0, so group i's
  // triplet is simply w_mult_ext[2i+2:2i].
  logic [DATA_W:0]        w_mult_ext;
  logic [3*NUM_PP-1:0]    w_enc;
  logic                   w_all_mag_zero;

  logic [DATA_W-1:0]      r_data [2];
  logic [3*NUM_PP-1:0]    r_enc  [2];
  logic                   r_wr_ptr;
  logic                   r_rd_ptr;
  logic [1:0]             r_count;
  logic                   r_in_ready;

  logic                   w_push;
  logic                   w_pop;
  logic [1:0]             w_count_nxt;

  assign w_mult_ext = {multiplier, 1'b0};

  // Booth recoding of each overlapping triplet; zero is always emitted positive.
  always_comb begin
    w_enc          = '0;
    w_all_mag_zero = 1'b1;
    for (int i = 0; i < NUM_PP; i++) begin
      case (w_mult_ext[2*i +: 3])
        3'b000:  w_enc[3*i +: 3] = 3'b000;
        3'b001:  w_enc[3*i +: 3] = 3'b001;
        3'b010:  w_enc[3*i +: 3] = 3'b001;
        3'b011:  w_enc[3*i +: 3] = 3'b010;
        3'b100:  w_enc[3*i +: 3] = 3'b110;
        3'b101:  w_enc[3*i +: 3] = 3'b101;
        3'b110:  w_enc[3*i +: 3] = 3'b101;
        default: w_enc[3*i +: 3] = 3'b000;
      endcase
      if (w_enc[3*i +: 2] != 2'b00) begin
        w_all_mag_zero = 1'b0;
      end
    end
  end

  assign w_push      = in_valid && r_in_ready;
  assign w_pop       = (r_count != 2'd0) && out_ready;
  assign w_count_nxt = r_count + {1'b0, w_push} - {1'b0, w_pop};

  // Pointer, occupancy and registered ready bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_count    <= 2'd0;
      r_in_ready <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_count    <= w_count_nxt;
      r_in_ready <= (w_count_nxt < 2'd2);
    end
  end

  // Entry storage; cleared on reset so the outputs read zero afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        r_data[k] <= '0;
        r_enc[k]  <= '0;
      end
    end else if (w_push) begin
      r_data[r_wr_ptr] <= multiplicand;
      r_enc[r_wr_ptr]  <= w_enc;
    end
  end

`ifdef BOOTH_ZERO_FLAG_EN
  logic w_zero;
  logic r_zero [2];

  assign w_zero = w_all_mag_zero || (multiplicand == '0);

  // Zero-product flag, buffered alongside the codes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zero[0] <= 1'b0;
      r_zero[1] <= 1'b0;
    end else if (w_push) begin
      r_zero[r_wr_ptr] <= w_zero;
    end
  end

  assign out_zero = r_zero[r_rd_ptr];
`else
  logic w_unused_zero;
  assign w_unused_zero = w_all_mag_zero;
`endif

  assign in_ready  = r_in_ready;
  assign out_valid = (r_count != 2'd0);
  assign out_data  = r_data[r_rd_ptr];
  assign out_enc   = r_enc[r_rd_ptr];

endmodule

// File: tb/tb_booth_enc_stage.sv
// Testbench for booth_enc_stage: directed encodings, back-pressure, streaming,
// asynchronous reset and randomized traffic against a queue-based model.
module tb_booth_enc_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] multiplicand;
  logic [15:0] multiplier;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [23:0] out_enc;
`ifdef BOOTH_ZERO_FLAG_EN
  logic        out_zero;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    logic [15:0] d;
    logic [23:0] e;
    logic        z;
  } entry_t;

  entry_t q[$];

  booth_enc_stage #(.DATA_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_enc      (out_enc)
`ifdef BOOTH_ZERO_FLAG_EN
    ,
    .out_zero     (out_zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Booth digit d = -2*b[2i+1] + b[2i] + b[2i-1] in {-2..2}, coded as sign + |d|.
  function automatic logic [23:0] ref_enc(input logic [15:0] m);
    logic [16:0] ext;
    logic [23:0] r;
    int          dg;
    logic [1:0]  mag;
    ext = {m, 1'b0};
    r   = '0;
    for (int i = 0; i < 8; i++) begin
      dg  = -2 * int'(ext[2*i+2]) + int'(ext[2*i+1]) + int'(ext[2*i]);
      mag = (dg < 0) ? 2'(-dg) : 2'(dg);
      r[3*i +: 3] = {dg < 0, mag};
    end
    return r;
  endfunction

  function automatic logic ref_zero(input logic [15:0] mc, input logic [15:0] mp);
    return (32'($signed(mc)) * 32'($signed(mp))) == 32'sd0;
  endfunction

  // Drive one cycle of inputs and advance the model by the transfers that the
  // next rising edge will perform. Called just after a falling edge.
  task automatic apply(input logic v, input logic [15:0] mc, input logic [15:0] mp,
                       input logic rdy, input logic [23:0] enc_exp);
    entry_t en;
    logic   push;
    logic   pop;
    in_valid     = v;
    multiplicand = mc;
    multiplier   = mp;
    out_ready    = rdy;
    push = v && (q.size() < 2);
    pop  = rdy && (q.size() != 0);
    if (pop) void'(q.pop_front());
    if (push) begin
      en.d = mc;
      en.e = enc_exp;
      en.z = ref_zero(mc, mp);
      q.push_back(en);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; multiplicand = '0; multiplier = '0;
    #12;
    n_checks++; if (out_valid !== 1'b0) begin n_fails++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fails++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_checks++; if (out_enc !== 24'h0) begin n_fails++; $display("FAIL reset_out_enc got=%h exp=0", out_enc); end
    n_checks++; if (out_data !== 16'h0) begin n_fails++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
`ifdef BOOTH_ZERO_FLAG_EN
    n_checks++; if (out_zero !== 1'b0) begin n_fails++; $display("FAIL reset_out_zero got=%b exp=0", out_zero); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_encoding;
    logic [15:0] mp_t [4] = '{16'h0001, 16'hFFFF, 16'h0002, 16'h8000};
    logic [15:0] mc_t [4] = '{16'h1234, 16'hA5A5, 16'h0F0F, 16'h7FFF};
    logic [23:0] ex_t [4] = '{24'h000001, 24'h000005, 24'h00000E, 24'hC00000};
    for (int i = 0; i < 5; i++) begin
      if (i < 4) apply(1'b1, mc_t[i], mp_t[i], 1'b1, ex_t[i]);
      else       apply(1'b0, 16'h0, 16'h0, 1'b1, 24'h0);
      @(negedge clk);
      n_checks++; if (out_valid !== (q.size() != 0)) begin n_fails++; $display("FAIL enc_valid[%0d] got=%b exp=%b", i, out_valid, q.size() != 0); end
      if (q.size() != 0) begin
        n_checks++; if (out_enc !== q[0].e) begin n_fails++; $display("FAIL enc_code[%0d] got=%h exp=%h", i, out_enc, q[0].e); end
        n_checks++; if (out_data !== q[0].d) begin n_fails++; $display("FAIL enc_data[%0d] got=%h exp=%h", i, out_data, q[0].d); end
        n_checks++; if (ref_enc(mp_t[i]) !== ex_t[i]) begin n_fails++; $display("FAIL enc_refmodel[%0d] got=%h exp=%h", i, ref_enc(mp_t[i]), ex_t[i]); end
      end
    end
  endtask

  task automatic test_back_pressure;
    logic [15:0] a = 16'h1111, b = 16'h2222, c = 16'h3333;
    logic [15:0] pa = 16'h0003, pb = 16'h7FFE, pc = 16'hC3A5;
    logic        v   [7] = '{1, 1, 1, 1, 1, 1, 0};
    logic        rdy [7] = '{0, 0, 0, 0, 1, 1, 1};
    logic [15:0] mc, mp;
    for (int s = 0; s < 7; s++) begin
      mc = (s == 0) ? a : (s == 1) ? b : c;
      mp = (s == 0) ? pa : (s == 1) ? pb : pc;
      apply(v[s], mc, mp, rdy[s], ref_enc(mp));
      @(negedge clk);
      n_checks++; if (in_ready !== (q.size() < 2)) begin n_fails++; $display("FAIL bp_in_ready[%0d] got=%b exp=%b", s, in_ready, q.size() < 2); end
      n_checks++; if (out_valid !== (q.size() != 0)) begin n_fails++; $display("FAIL bp_valid[%0d] got=%b exp=%b", s, out_valid, q.size() != 0); end
      if (q.size() != 0) begin
        n_checks++; if (out_data !== q[0].d) begin n_fails++; $display("FAIL bp_data[%0d] got=%h exp=%h", s, out_data, q[0].d); end
        n_checks++; if (out_enc !== q[0].e) begin n_fails++; $display("FAIL bp_enc[%0d] got=%h exp=%h", s, out_enc, q[0].e); end
      end
    end
    n_checks++; if (q.size() != 0) begin n_fails++; $display("FAIL bp_drain got=%0d exp=0", q.size()); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] mc, mp;
    int          seen = 0;
    for (int i = 0; i < 17; i++) begin
      mc = 16'($urandom); mp = 16'($urandom);
      if (i < 16) apply(1'b1, mc, mp, 1'b1, ref_enc(mp));
      else        apply(1'b0, 16'h0, 16'h0, 1'b1, 24'h0);
      @(negedge clk);
      if (i < 16) begin
        n_checks++; if (in_ready !== 1'b1) begin n_fails++; $display("FAIL stream_in_ready[%0d] got=%b exp=1", i, in_ready); end
      end
      n_checks++; if (out_valid !== (i < 16)) begin n_fails++; $display("FAIL stream_valid[%0d] got=%b exp=%b", i, out_valid, i < 16); end
      if (q.size() != 0 && out_valid === 1'b1) begin
        seen++;
        n_checks++; if ({out_data, out_enc} !== {q[0].d, q[0].e}) begin n_fails++; $display("FAIL stream_entry[%0d] got=%h/%h exp=%h/%h", i, out_data, out_enc, q[0].d, q[0].e); end
      end
    end
    n_checks++; if (seen != 16) begin n_fails++; $display("FAIL stream_count got=%0d exp=16", seen); end
  endtask

  task automatic test_mid_reset;
    apply(1'b1, 16'hBEEF, 16'h1357, 1'b0, ref_enc(16'h1357));
    @(negedge clk);
    apply(1'b1, 16'hCAFE, 16'h2468, 1'b0, ref_enc(16'h2468));
    @(negedge clk);
    apply(1'b0, 16'h0, 16'h0, 1'b0, 24'h0);
    n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_fails++; $display("FAIL mrst_full got=%b/%b exp=1/0", out_valid, in_ready); end
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    n_checks++; if (out_valid !== 1'b0) begin n_fails++; $display("FAIL mrst_valid got=%b exp=0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fails++; $display("FAIL mrst_in_ready got=%b exp=1", in_ready); end
    n_checks++; if (out_enc !== 24'h0 || out_data !== 16'h0) begin n_fails++; $display("FAIL mrst_outputs got=%h/%h exp=0/0", out_data, out_enc); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 16'h0, 16'h0, 1'b1, 24'h0);
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b0) begin n_fails++; $display("FAIL mrst_stale[%0d] got=%b exp=0", i, out_valid); end
    end
    apply(1'b1, 16'h4242, 16'h0001, 1'b0, ref_enc(16'h0001));
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1 || out_data !== 16'h4242 || out_enc !== 24'h000001) begin
      n_fails++; $display("FAIL mrst_first got=%b/%h/%h exp=1/4242/000001", out_valid, out_data, out_enc);
    end
    apply(1'b0, 16'h0, 16'h0, 1'b1, 24'h0);
    @(negedge clk);
  endtask

`ifdef BOOTH_ZERO_FLAG_EN
  task automatic test_zero_flag;
    logic [15:0] mp_t [3] = '{16'hFFFF, 16'h0000, 16'h0001};
    logic [15:0] mc_t [3] = '{16'h0000, 16'h5555, 16'h0003};
    logic        ex_t [3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, mc_t[i], mp_t[i], 1'b0, ref_enc(mp_t[i]));
      @(negedge clk);
      n_checks++; if (out_zero !== ex_t[i]) begin n_fails++; $display("FAIL zero_flag[%0d] got=%b exp=%b", i, out_zero, ex_t[i]); end
      apply(1'b0, 16'h0, 16'h0, 1'b1, 24'h0);
      @(negedge clk);
    end
  endtask
`endif

  task automatic test_random;
    logic [15:0] mc, mp;
    for (int i = 0; i < 300; i++) begin
      mc = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      mp = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      apply(1'($urandom_range(0, 3) != 0), mc, mp, 1'($urandom_range(0, 2) != 0), ref_enc(mp));
      @(negedge clk);
      n_checks++; if (in_ready !== (q.size() < 2)) begin n_fails++; $display("FAIL rnd_in_ready[%0d] got=%b exp=%b", i, in_ready, q.size() < 2); end
      n_checks++; if (out_valid !== (q.size() != 0)) begin n_fails++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", i, out_valid, q.size() != 0); end
      if (q.size() != 0) begin
        n_checks++; if ({out_data, out_enc} !== {q[0].d, q[0].e}) begin n_fails++; $display("FAIL rnd_entry[%0d] got=%h/%h exp=%h/%h", i, out_data, out_enc, q[0].d, q[0].e); end
`ifdef BOOTH_ZERO_FLAG_EN
        n_checks++; if (out_zero !== q[0].z) begin n_fails++; $display("FAIL rnd_zero[%0d] got=%b exp=%b", i, out_zero, q[0].z); end
`endif
      end
    end
    apply(1'b0, 16'h0, 16'h0, 1'b1, 24'h0);
    @(negedge clk);
    apply(1'b0, 16'h0, 16'h0, 1'b1, 24'h0);
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_encoding();
    test_back_pressure();
    test_back_to_back();
    test_mid_reset();
`ifdef BOOTH_ZERO_FLAG_EN
    test_zero_flag();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
